spi_reg_writer: RTL and testbench

//  SPI controller (initiator) that drives the SCLK/COPI/nCS pins of the onboarding SPI register peripheral.

---
 rtl/spi_frame_pkg.sv | 35 +++
 rtl/spi_tick_gen.sv | 41 ++++
 rtl/spi_reg_writer.sv | 176 +++++++++++++++++
 tb/tb_spi_reg_writer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// ============================================================================
// Module      : spi_frame_pkg
// Description : Frame layout, FSM states and frame packing shared by the SPI
//               register writer and the SPI register peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int RW_BIT     = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } state_t;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              write,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {write, addr, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tick_gen.sv
// ============================================================================
// Module      : spi_tick_gen
// Description : Loadable down-counter; expire pulses for one cycle when a
//               loaded count has run down to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tick_gen #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;
    logic             r_armed;

    // The armed flag keeps an idle zero count from looking like a fresh expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_armed <= 1'b1;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end else begin
            r_armed <= 1'b0;
        end
    end

    assign expire = r_armed && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/spi_reg_writer.sv
// ============================================================================
// Module      : spi_reg_writer
// Description : SPI mode-0 initiator; sends one 16-bit {rw,addr,data} frame,
//               MSB first, per accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_writer
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              sclk,
    output logic              copi,
    output logic              ncs,
    output logic              busy,
    output logic              done
);

    localparam int c_max_cnt = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_cnt_w   = $clog2(c_max_cnt + 1);
    localparam logic [c_cnt_w-1:0] c_div_ld = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_gap_ld = c_cnt_w'(CS_GAP - 1);

    state_t                  r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]   r_shift, w_shift_nxt;
    logic [3:0]              r_bit_cnt, w_bit_cnt_nxt;
    logic                    r_hold_ext, w_hold_ext_nxt;
    logic                    r_sclk, w_sclk_nxt;
    logic                    r_copi, w_copi_nxt;
    logic                    r_ncs, w_ncs_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_done, w_done_nxt;
    logic                    w_load;
    logic [c_cnt_w-1:0]      w_load_val;
    logic                    w_expire;
    logic [FRAME_BITS-1:0]   w_frame;

    spi_tick_gen #(
        .CNT_W (c_cnt_w)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .expire   (w_expire)
    );

    assign w_frame   = pack_frame(req_write, req_addr, req_data);
    assign req_ready = (r_state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_hold_ext <= 1'b0;
            r_sclk     <= 1'b0;
            r_copi     <= 1'b0;
            r_ncs      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_hold_ext <= w_hold_ext_nxt;
            r_sclk     <= w_sclk_nxt;
            r_copi     <= w_copi_nxt;
            r_ncs      <= w_ncs_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_hold_ext_nxt = r_hold_ext;
        w_sclk_nxt     = r_sclk;
        w_copi_nxt     = r_copi;
        w_ncs_nxt      = r_ncs;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_load         = 1'b0;
        w_load_val     = c_div_ld;

        case (r_state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    w_state_nxt   = SETUP;
                    w_shift_nxt   = w_frame;
                    w_copi_nxt    = w_frame[RW_BIT];
                    w_bit_cnt_nxt = 4'(FRAME_BITS - 1);
                    w_ncs_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_load        = 1'b1;
                end
            end
            SETUP: begin
                if (w_expire) begin
                    w_state_nxt = SHIFT_HI;
                    w_sclk_nxt  = 1'b1;
                    w_load      = 1'b1;
                end
            end
            SHIFT_HI: begin
                // Falling edge: the next bit is launched here so it is
                // centred on the following rising edge.
                if (w_expire) begin
                    w_sclk_nxt = 1'b0;
                    w_load     = 1'b1;
                    if (r_bit_cnt == '0) begin
                        w_state_nxt    = HOLD;
                        w_hold_ext_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = SHIFT_LO;
                        w_shift_nxt   = {r_shift[FRAME_BITS-2:0], 1'b0};
                        w_copi_nxt    = r_shift[FRAME_BITS-2];
                        w_bit_cnt_nxt = r_bit_cnt - 4'd1;
                    end
                end
            end
            SHIFT_LO: begin
                if (w_expire) begin
                    w_state_nxt = SHIFT_HI;
                    w_sclk_nxt  = 1'b1;
                    w_load      = 1'b1;
                end
            end
            HOLD: begin
                // Two half-periods of hold give a full 34 half-period nCS window.
                if (w_expire) begin
                    w_load = 1'b1;
                    if (!r_hold_ext) begin
                        w_hold_ext_nxt = 1'b1;
                    end else begin
                        w_state_nxt = GAP;
                        w_ncs_nxt   = 1'b1;
                        w_copi_nxt  = 1'b0;
                        w_load_val  = c_gap_ld;
                    end
                end
            end
            GAP: begin
                if (w_expire) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign sclk = r_sclk;
    assign copi = r_copi;
    assign ncs  = r_ncs;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_writer.sv
// ============================================================================
// Module      : tb_spi_reg_writer
// Description : Self-checking bench for spi_reg_writer at CLK_DIV=4/CS_GAP=2
//               and CLK_DIV=1/CS_GAP=1, with a behavioural SPI peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]      rst, req_valid, req_ready, req_write;
    logic [1:0][6:0] req_addr;
    logic [1:0][7:0] req_data;
    logic [1:0]      sclk, copi, ncs, busy, done;

    spi_reg_writer #(.CLK_DIV(4), .CS_GAP(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
        .sclk(sclk[0]), .copi(copi[0]), .ncs(ncs[0]), .busy(busy[0]), .done(done[0])
    );

    spi_reg_writer #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
        .sclk(sclk[1]), .copi(copi[1]), .ncs(ncs[1]), .busy(busy[1]), .done(done[1])
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] exp_regs [2][128];
    logic [7:0] per_regs [2][128];
    int         last_ncs_rise [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sends one request and follows the frame; called and returning on a negedge.
    task automatic do_frame(input int k, input logic w, input logic [6:0] a,
                            input logic [7:0] d, input int abort_rise, input bit hold_valid);
        int c, g, acc, low, rises, done_n, done_t, fall_cyc, rise_ncs, chg_cyc, rise_cyc, wait_n;
        logic [15:0] cap, exp_frame;
        logic prev_sclk, prev_copi;
        bit stable_ok, got;

        c = (k == 0) ? 4 : 1;
        g = (k == 0) ? 2 : 1;
        exp_frame = {w, a, d};
        req_write[k] = w; req_addr[k] = a; req_data[k] = d; req_valid[k] = 1'b1;

        wait_n = 0;
        while (!req_ready[k] && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (!req_ready[k]) begin
            check("accept_timeout", 0, 1);
            req_valid[k] = 1'b0;
            return;
        end
        acc = cyc;
        prev_copi = copi[k];
        @(posedge clk);
        #1;
        req_valid[k] = hold_valid;
        req_write[k] = 1'($urandom);
        req_addr[k]  = 7'($urandom);
        req_data[k]  = 8'($urandom);

        low = 0; rises = 0; done_n = 0; done_t = -1; fall_cyc = -1; rise_ncs = -1;
        cap = '0; prev_sclk = 1'b0; stable_ok = 1'b1; chg_cyc = acc; rise_cyc = -1000;
        for (int t = 1; t <= 34 * c + g + 8; t++) begin
            @(negedge clk);
            if (!ncs[k]) begin
                low++;
                if (fall_cyc < 0) fall_cyc = cyc;
                if (copi[k] != prev_copi) begin
                    if (cyc - rise_cyc < c) stable_ok = 1'b0;
                    chg_cyc = cyc;
                end
                if (sclk[k] && !prev_sclk) begin
                    rises++;
                    cap = {cap[14:0], copi[k]};
                    if (cyc - chg_cyc < c) stable_ok = 1'b0;
                    rise_cyc = cyc;
                    if (rises == 1) check("ready_busy_in_frame", {req_ready[k], busy[k]}, 2'b01);
                    if (rises == abort_rise) break;
                end
            end else if (low > 0 && rise_ncs < 0) begin
                rise_ncs = cyc;
            end
            prev_sclk = sclk[k];
            prev_copi = copi[k];
            if (done[k]) begin
                done_n++;
                done_t = t;
                check("ready_at_done", req_ready[k], 1);
                break;
            end
        end

        if (abort_rise > 0) begin
            rst[k] = 1'b1;
            @(negedge clk);
            check("rst_pins", {ncs[k], sclk[k], copi[k], busy[k], req_ready[k]}, 5'b10000);
            rst[k] = 1'b0;
            @(negedge clk);
            check("ready_after_rst", req_ready[k], 1);
            got = 1'b0;
            for (int i = 0; i < 34 * c + g + 4; i++) begin
                if (done[k] || !ncs[k]) got = 1'b1;
                @(negedge clk);
            end
            check("quiet_after_rst", got, 0);
            check("reg_after_abort", per_regs[k][a], exp_regs[k][a]);
            last_ncs_rise[k] = -1;
            return;
        end

        check("done_once", done_n, 1);
        check("done_latency", done_t, 34 * c + g + 1);
        check("ncs_low_cycles", low, 34 * c);
        check("sclk_rises", rises, 16);
        check("frame", cap, exp_frame);
        check("copi_stable", stable_ok, 1);
        if (last_ncs_rise[k] >= 0) check("cs_gap", fall_cyc - last_ncs_rise[k], g + 1);
        last_ncs_rise[k] = rise_ncs;

        // Peripheral acts on complete frames only; the model on the request.
        if (rises == 16 && cap[15]) per_regs[k][cap[14:8]] = cap[7:0];
        if (w) exp_regs[k][a] = d;
        check("periph_reg", per_regs[k][a], exp_regs[k][a]);
    endtask

    initial begin
        rst = '1; req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
        last_ncs_rise[0] = -1;
        last_ncs_rise[1] = -1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 128; i++) begin
                exp_regs[k][i] = 8'h00;
                per_regs[k][i] = 8'h00;
            end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("reset_pins", {ncs[k], sclk[k], copi[k], busy[k], done[k], req_ready[k]}, 6'b100000);
        rst = '0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("ready_idle", req_ready[k], 1);

        do_frame(0, 1'b1, 7'h00, 8'hFF, 0, 1'b0);
        do_frame(0, 1'b1, 7'h02, 8'h55, 0, 1'b0);
        do_frame(0, 1'b1, 7'h04, 8'hAA, 0, 1'b0);
        do_frame(0, 1'b1, 7'(20 + $urandom_range(0, 9)), 8'($urandom), 0, 1'b1);
        do_frame(0, 1'b1, 7'(40 + $urandom_range(0, 9)), 8'($urandom), 0, 1'b0);
        do_frame(0, 1'b1, 7'h02, 8'h33, 7, 1'b0);
        check("reg02_kept", per_regs[0][2], 8'h55);
        do_frame(0, 1'b0, 7'h7F, 8'h00, 0, 1'b0);
        for (int i = 0; i < 6; i++)
            do_frame(0, 1'($urandom), 7'($urandom), 8'($urandom), 0, 1'(i < 5 && i[0]));

        do_frame(1, 1'b1, 7'h01, 8'hA5, 0, 1'b0);
        for (int i = 0; i < 6; i++)
            do_frame(1, 1'($urandom), 7'($urandom), 8'($urandom), 0, 1'(i < 5 && !i[0]));
        do_frame(1, 1'b1, 7'h05, 8'h3C, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
